// File: rtl/stream_fifo_flushable.sv
// Valid/ready FIFO with synchronous single-cycle flush and optional fall-through.
// Depth need not be a power of two; pointers wrap by explicit compare.
module stream_fifo_flushable #(
  parameter type         T           = logic,
  parameter int unsigned Depth       = 4,
  parameter bit          FallThrough = 1'b0,
  localparam int unsigned AddrW      = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  T             data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output T             data_o,
  output logic [AddrW:0] usage_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned        CntW     = AddrW + 1;
  localparam logic [AddrW-1:0]   LastPtr  = AddrW'(Depth - 1);
  localparam logic [CntW-1:0]    DepthCnt = CntW'(Depth);

  if (Depth == 0) begin : g_bad_depth
    $fatal(1, "stream_fifo_flushable: Depth must be at least 1");
  end

  T                 mem_q [Depth];
  logic [AddrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             empty, full, bypass, push, pop;

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] p);
    return (p == LastPtr) ? '0 : p + AddrW'(1);
  endfunction

  // Handshake decode; outputs depend on registered state plus the FT bypass path.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DepthCnt);
    bypass  = FallThrough && empty && valid_i && ready_i;
    ready_o = !full;
    valid_o = !empty || (FallThrough && valid_i);
    data_o  = (FallThrough && empty) ? data_i : mem_q[rd_ptr_q];
    push    = valid_i && !full && !flush_i && !bypass;
    pop     = !empty && ready_i && !flush_i;
    usage_o = count_q;
    full_o  = full;
    empty_o = empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  a_flush_with_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(flush_i && valid_i))
    else $warning("stream_fifo_flushable: valid_i during flush_i, beat dropped");

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= DepthCnt);

  a_full_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(full_o && empty_o));

  a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> valid_o);

endmodule
